mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single unified memory port (ROM at 0x0000_0000–0x0FFF, RAM at 0x1000–0x2FFF) between the instruction-fetch (IF) requester and the load/store (LS) requester of the RV32I core. It performs round-robin arbitration, one outstanding transaction, address-range and alignment checking, byte-enable generation and load-data extraction/extension. It sits between the fetch/LSU stages and the ROM/RAM wrapper.

Parameters:
MEM_LAT_MAX, 16, watchdog cycles in BUSY without mem_ready_i before the transaction is aborted with error (0 disables).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
if_req_i  in  1  fetch request, held until if_gnt_o
if_addr_i  in  32  fetch byte address
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  one-cycle fetch response strobe
if_rdata_o  out  32  instruction word (BAD_VAL on error)
if_err_o  out  1  fetch error, valid with if_rvalid_o
ls_req_i  in  1  load/store request, held until ls_gnt_o
ls_addr_i  in  32  data byte address
ls_read_i  in  3  mem_read_t
ls_write_i  in  2  mem_write_t
ls_wdata_i  in  32  store data, right-aligned
ls_gnt_o  out  1  LS request accepted this cycle
ls_rvalid_o  out  1  one-cycle LS response strobe (loads and stores)
ls_rdata_o  out  32  extended load data; 0 for stores; BAD_VAL on error
ls_err_o  out  1  LS error, valid with ls_rvalid_o
mem_req_o  out  1  memory request, held until mem_ready_i
mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
mem_we_o  out  1  write enable
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated store data
mem_ready_i  in  1  memory completes current request this cycle
mem_rdata_i  in  32  read word, valid with mem_ready_i

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). On reset every output is 0, state IDLE, last_owner = IF. Reset mid-transaction drops it silently; no response is issued.
- FSM states: IDLE, BUSY, RESP, ERR.
- IDLE: an LS request is valid only if ls_read_i != MEM_READ_NONE xor ls_write_i != MEM_WRITE_NONE. If both are non-NONE, or both are NONE, with ls_req_i high, the request is an error.
- IDLE, single requester: that requester is granted. Both requesting: the one != last_owner is granted, so the first conflict after reset goes to LS.
- gnt_o is combinational in IDLE and is a single-cycle pulse. On grant, addr/type/wdata/owner are latched and last_owner is updated.
- Check at grant: address must lie in [ROM_BASE_ADDR, RAM_END_ADDR). Alignment: word requires addr[1:0]==0, half requires addr[0]==0; fetch is always word. Any store to ROM fails. Any failed check -> ERR; otherwise -> BUSY.
- BUSY: mem_req_o=1 with stable addr/we/be/wdata. On mem_ready_i, rdata is captured and the FSM goes to RESP. If the watchdog expires (MEM_LAT_MAX cycles) -> ERR.
- RESP: owner's rvalid_o=1 for exactly one cycle with err_o=0, then IDLE. No new grant in RESP.
- ERR: owner's rvalid_o=1 and err_o=1, rdata=BAD_VAL, one cycle, then IDLE.
- Minimum latency: grant at cycle T, mem_req_o at T+1, ready at T+1, rvalid at T+2. Throughput is at most one transaction per 3 cycles.
- Byte enables, with off = addr[1:0]: BYTE -> 4'b0001<<off; HALF -> 4'b0011<<off; WORD -> 4'b1111. Reads also drive full be = 4'b1111.
- Store data: byte replicated x4, half replicated x2, word as-is.
- Load extraction: select the lane by off. BYTE and HALF sign-extend; BYTE_U and HALF_U zero-extend; WORD passes through.
- The non-owner's rvalid_o, rdata_o and err_o are 0. rdata_o outputs are 0 when rvalid_o=0.

Decomposition:
- Package typepkg additions: arb_state_t {IDLE,BUSY,RESP,ERR}, arb_owner_t {OWNER_IF,OWNER_LS}.
- Reuse the existing typepkg items: mem_read_t, mem_write_t, BAD_VAL, ROM/RAM address constants.
- One combinational sub-module, mem_lane_align: inputs are offset, mem_read_t and mem_write_t; it produces be, replicated wdata and the extended load word.

Test Plan:
- IF only, addr 0x0000_0010, ready 1 cycle after req, rdata 0x00000013 -> gnt at T, mem_addr 0x10, be 1111, if_rvalid at T+2, if_rdata 0x00000013, err 0.
- Both requesting from reset: IF 0x0, LS LW 0x1000 -> LS granted first, then IF granted in the next IDLE; a third conflict goes to LS.
- LB at 0x1003, mem_rdata 0x80FF_0000 -> be 1000 (read be 1111), ls_rdata 0xFFFF_FF80. The same access as LBU -> 0x0000_0080.
- SH at 0x1002, wdata 0x1234_ABCD -> mem_we 1, be 1100, mem_wdata 0xABCD_ABCD; ls_rvalid with rdata 0.
- Errors: LW at 0x1001, SW at 0x0000_0100 (ROM), and LW at 0x3000 -> no mem_req_o, ls_err 1, rdata 0xDEAD_BEEF. mem_ready_i held low for 16 cycles -> error.
- rst_n pulsed low while in BUSY -> all outputs 0 immediately, no rvalid afterwards; the next conflict is granted to LS.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        MEM_READ_NONE   = 3'd0,
        MEM_READ_BYTE   = 3'd1,
        MEM_READ_HALF   = 3'd2,
        MEM_READ_WORD   = 3'd3,
        MEM_READ_BYTE_U = 3'd4,
        MEM_READ_HALF_U = 3'd5
    } mem_read_t;

    typedef enum logic [1:0] {
        MEM_WRITE_NONE = 2'd0,
        MEM_WRITE_BYTE = 2'd1,
        MEM_WRITE_HALF = 2'd2,
        MEM_WRITE_WORD = 2'd3
    } mem_write_t;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} arb_state_t;
    typedef enum logic {OWNER_IF, OWNER_LS} arb_owner_t;

    localparam logic [31:0] BAD_VAL       = 32'hDEAD_BEEF;
    localparam logic [31:0] ROM_BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0] ROM_END_ADDR  = 32'h0000_1000;
    localparam logic [31:0] RAM_BASE_ADDR = 32'h0000_1000;
    localparam logic [31:0] RAM_END_ADDR  = 32'h0000_3000;

    // Transaction latched at grant and held stable for the whole access.
    typedef struct packed {
        arb_owner_t  owner;
        mem_read_t   rd;
        mem_write_t  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } arb_req_t;

    // Half-open range test; the subtraction keeps it correct for a zero base.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] lim);
        return (addr - base) < (lim - base);
    endfunction

    function automatic logic misaligned(input logic [1:0] off,
                                        input mem_read_t  rd,
                                        input mem_write_t wr);
        logic is_word;
        logic is_half;
        is_word = (rd == MEM_READ_WORD) || (wr == MEM_WRITE_WORD);
        is_half = (rd == MEM_READ_HALF) || (rd == MEM_READ_HALF_U) || (wr == MEM_WRITE_HALF);
        return (is_word && (off != 2'b00)) || (is_half && off[0]);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane steering: byte enables, store replication, load extraction/extension.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  off,
    input  mem_read_t   rd,
    input  mem_write_t  wr,
    input  logic [31:0] wdata_raw,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] lane;

    assign lane = rdata_raw >> {off, 3'b000};

    always_comb begin
        be    = 4'b1111;
        wdata = '0;
        case (wr)
            MEM_WRITE_BYTE: begin
                be    = 4'b0001 << off;
                wdata = {4{wdata_raw[7:0]}};
            end
            MEM_WRITE_HALF: begin
                be    = 4'b0011 << off;
                wdata = {2{wdata_raw[15:0]}};
            end
            MEM_WRITE_WORD: begin
                wdata = wdata_raw;
            end
            default: ;
        endcase
    end

    // Stores (rd == NONE) return zero.
    always_comb begin
        rdata = '0;
        case (rd)
            MEM_READ_BYTE:   rdata = {{24{lane[7]}}, lane[7:0]};
            MEM_READ_BYTE_U: rdata = {24'h0, lane[7:0]};
            MEM_READ_HALF:   rdata = {{16{lane[15]}}, lane[15:0]};
            MEM_READ_HALF_U: rdata = {16'h0, lane[15:0]};
            MEM_READ_WORD:   rdata = rdata_raw;
            default:         rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin IF/LS arbiter onto the single ROM/RAM port, one transaction in flight.
// Latency: grant T, mem_req T+1, rvalid >= T+2; at most one transaction per 3 cycles.
// Backpressure: requesters hold req until gnt; memory stalls via mem_ready_i (watchdog bounded).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        ls_req_i,
    input  logic [31:0] ls_addr_i,
    input  logic [2:0]  ls_read_i,
    input  logic [1:0]  ls_write_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        ls_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int              WD_W    = (MEM_LAT_MAX > 1) ? $clog2(MEM_LAT_MAX) : 1;
    localparam bit              WD_EN   = (MEM_LAT_MAX > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_LAT_MAX > 0) ? MEM_LAT_MAX - 1 : 0);

    arb_state_t      state_q, state_d;
    arb_owner_t      last_owner_q, last_owner_d;
    arb_req_t        req_q, req_d, new_req;
    logic [31:0]     rdata_q, rdata_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    mem_read_t   ls_rd;
    mem_write_t  ls_wr;
    logic        ls_type_ok;
    logic        grant_if, grant_ls;
    logic        chk_fail;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_rdata;

    assign ls_rd      = mem_read_t'(ls_read_i);
    assign ls_wr      = mem_write_t'(ls_write_i);
    assign ls_type_ok = (ls_rd != MEM_READ_NONE) ^ (ls_wr != MEM_WRITE_NONE);

    // On a conflict the port goes to whoever did not own it last.
    assign grant_ls = (state_q == IDLE) && rst_n && ls_req_i &&
                      (!if_req_i || (last_owner_q == OWNER_IF));
    assign grant_if = (state_q == IDLE) && rst_n && if_req_i && !grant_ls;

    always_comb begin
        new_req = '0;
        if (grant_ls) begin
            new_req.owner = OWNER_LS;
            new_req.rd    = ls_rd;
            new_req.wr    = ls_wr;
            new_req.addr  = ls_addr_i;
            new_req.wdata = ls_wdata_i;
        end else begin
            new_req.owner = OWNER_IF;
            new_req.rd    = MEM_READ_WORD;
            new_req.wr    = MEM_WRITE_NONE;
            new_req.addr  = if_addr_i;
            new_req.wdata = '0;
        end
    end

    always_comb begin
        chk_fail = !in_range(new_req.addr, ROM_BASE_ADDR, RAM_END_ADDR);
        if (grant_ls && !ls_type_ok) begin
            chk_fail = 1'b1;
        end
        if (misaligned(new_req.addr[1:0], new_req.rd, new_req.wr)) begin
            chk_fail = 1'b1;
        end
        if ((new_req.wr != MEM_WRITE_NONE) && in_range(new_req.addr, ROM_BASE_ADDR, ROM_END_ADDR)) begin
            chk_fail = 1'b1;
        end
    end

    mem_lane_align u_lane_align (
        .off       (req_q.addr[1:0]),
        .rd        (req_q.rd),
        .wr        (req_q.wr),
        .wdata_raw (req_q.wdata),
        .rdata_raw (mem_rdata_i),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .rdata     (lane_rdata)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        req_d        = req_q;
        rdata_d      = rdata_q;
        wd_cnt_d     = wd_cnt_q;
        if_gnt_o     = grant_if;
        ls_gnt_o     = grant_ls;
        if_rvalid_o  = 1'b0;
        if_rdata_o   = '0;
        if_err_o     = 1'b0;
        ls_rvalid_o  = 1'b0;
        ls_rdata_o   = '0;
        ls_err_o     = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_wdata_o  = '0;

        case (state_q)
            IDLE: begin
                if (grant_if || grant_ls) begin
                    req_d        = new_req;
                    last_owner_d = new_req.owner;
                    rdata_d      = '0;
                    wd_cnt_d     = '0;
                    state_d      = chk_fail ? ERR : BUSY;
                end
            end
            BUSY: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = {req_q.addr[31:2], 2'b00};
                mem_we_o    = (req_q.wr != MEM_WRITE_NONE);
                mem_be_o    = lane_be;
                mem_wdata_o = lane_wdata;
                // A completion in the last watchdog cycle still wins.
                if (mem_ready_i) begin
                    rdata_d = lane_rdata;
                    state_d = RESP;
                end else if (WD_EN && (wd_cnt_q == WD_LAST)) begin
                    state_d = ERR;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (req_q.owner == OWNER_LS) begin
                    ls_rvalid_o = 1'b1;
                    ls_rdata_o  = rdata_q;
                end else begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = rdata_q;
                end
                state_d = IDLE;
            end
            ERR: begin
                if (req_q.owner == OWNER_LS) begin
                    ls_rvalid_o = 1'b1;
                    ls_rdata_o  = BAD_VAL;
                    ls_err_o    = 1'b1;
                end else begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = BAD_VAL;
                    if_err_o    = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_IF;
            req_q        <= '0;
            rdata_q      <= '0;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            req_q        <= req_d;
            rdata_q      <= rdata_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: expected responses are queued at stimulus time and
// popped by a response monitor; port-side values are checked inline per scenario.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i;
    logic [31:0] ls_addr_i;
    logic [2:0]  ls_read_i;
    logic [1:0]  ls_write_i;
    logic [31:0] ls_wdata_i;
    logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
    logic [31:0] ls_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rv_count = 0;
    int last_rv_cyc = 0;
    int mem_lat = 0;
    int mem_wait = 0;
    logic [31:0] mem_word = 32'h0;
    logic [32:0] exp_if_q[$];
    logic [32:0] exp_ls_q[$];

    mem_port_arbiter #(.MEM_LAT_MAX(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .ls_req_i(ls_req_i), .ls_addr_i(ls_addr_i), .ls_read_i(ls_read_i),
        .ls_write_i(ls_write_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Memory model: completes after mem_lat stalled cycles of mem_req_o.
    initial begin
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_o) begin
                mem_ready_i = (mem_wait >= mem_lat);
                mem_rdata_i = mem_ready_i ? mem_word : 32'h0;
                mem_wait++;
            end else begin
                mem_ready_i = 1'b0;
                mem_rdata_i = 32'h0;
                mem_wait    = 0;
            end
        end
    end

    // Response monitor / scoreboard pop.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && (if_rvalid_o || ls_rvalid_o)) begin
                rv_count++;
                last_rv_cyc = cyc;
                if (if_rvalid_o) begin
                    total++;
                    if (exp_if_q.size() == 0) begin
                        bad++;
                        $display("FAIL if_resp_unexpected: got err=%b rdata=%h want no response", if_err_o, if_rdata_o);
                    end else begin
                        e = exp_if_q.pop_front();
                        if ({if_err_o, if_rdata_o, ls_rvalid_o, ls_err_o, ls_rdata_o} !== {e, 1'b0, 1'b0, 32'h0}) begin
                            bad++;
                            $display("FAIL if_resp: got err=%b rdata=%h ls_rv=%b want err=%b rdata=%h ls_rv=0",
                                     if_err_o, if_rdata_o, ls_rvalid_o, e[32], e[31:0]);
                        end
                    end
                end
                if (ls_rvalid_o) begin
                    total++;
                    if (exp_ls_q.size() == 0) begin
                        bad++;
                        $display("FAIL ls_resp_unexpected: got err=%b rdata=%h want no response", ls_err_o, ls_rdata_o);
                    end else begin
                        e = exp_ls_q.pop_front();
                        if ({ls_err_o, ls_rdata_o, if_rvalid_o, if_err_o, if_rdata_o} !== {e, 1'b0, 1'b0, 32'h0}) begin
                            bad++;
                            $display("FAIL ls_resp: got err=%b rdata=%h if_rv=%b want err=%b rdata=%h if_rv=0",
                                     ls_err_o, ls_rdata_o, if_rvalid_o, e[32], e[31:0]);
                        end
                    end
                end
            end else if (rst_n) begin
                total++;
                if ({if_rdata_o, if_err_o, ls_rdata_o, ls_err_o} !== 66'h0) begin
                    bad++;
                    $display("FAIL idle_rdata: got if=%h/%b ls=%h/%b want all 0", if_rdata_o, if_err_o, ls_rdata_o, ls_err_o);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && (exp_if_q.size() + exp_ls_q.size()) != 0; i++) @(negedge clk);
        total++;
        if ((exp_if_q.size() + exp_ls_q.size()) != 0) begin
            bad++;
            $display("FAIL %s drain: pending=%0d want 0", name, exp_if_q.size() + exp_ls_q.size());
            exp_if_q.delete();
            exp_ls_q.delete();
        end
    endtask

    task automatic ls_issue(input string name, input logic [31:0] addr, input mem_read_t rd,
                            input mem_write_t wr, input logic [31:0] wd, output int gcyc);
        bit got = 0;
        gcyc = 0;
        @(posedge clk);
        #1;
        ls_req_i = 1'b1; ls_addr_i = addr; ls_read_i = rd; ls_write_i = wr; ls_wdata_i = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ls_gnt_o) begin got = 1; gcyc = cyc; end
        end
        total++;
        if (!got) begin bad++; $display("FAIL %s ls_gnt: got 0 want 1", name); end
        @(posedge clk);
        #1;
        ls_req_i = 1'b0; ls_read_i = MEM_READ_NONE; ls_write_i = MEM_WRITE_NONE;
    endtask

    task automatic if_issue(input string name, input logic [31:0] addr, output int gcyc);
        bit got = 0;
        gcyc = 0;
        @(posedge clk);
        #1;
        if_req_i = 1'b1; if_addr_i = addr;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (if_gnt_o) begin got = 1; gcyc = cyc; end
        end
        total++;
        if (!got) begin bad++; $display("FAIL %s if_gnt: got 0 want 1", name); end
        @(posedge clk);
        #1;
        if_req_i = 1'b0;
    endtask

    task automatic ls_txn(input string name, input logic [31:0] addr, input mem_read_t rd,
                          input mem_write_t wr, input logic [31:0] wd, input logic [31:0] mword,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int gcyc;
        mem_word = mword;
        mem_lat  = 0;
        exp_ls_q.push_back({exp_err, exp_rd});
        ls_issue(name, addr, rd, wr, wd, gcyc);
        @(negedge clk);
        total++;
        if (exp_err) begin
            if (mem_req_o !== 1'b0) begin bad++; $display("FAIL %s mem_req: got %b want 0", name, mem_req_o); end
        end else begin
            if ({mem_req_o, mem_addr_o, mem_we_o, mem_be_o} !== {1'b1, addr[31:2], 2'b00, wr != MEM_WRITE_NONE, exp_be}) begin
                bad++;
                $display("FAIL %s mem_ctl: got req=%b addr=%h we=%b be=%b want req=1 addr=%h we=%b be=%b",
                         name, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, {addr[31:2], 2'b00}, wr != MEM_WRITE_NONE, exp_be);
            end
            if (wr != MEM_WRITE_NONE) begin
                total++;
                if (mem_wdata_o !== exp_wd) begin bad++; $display("FAIL %s mem_wdata: got %h want %h", name, mem_wdata_o, exp_wd); end
            end
        end
        wait_drain(name);
    endtask

    task automatic if_txn(input string name, input logic [31:0] addr, input logic [31:0] mword,
                          input logic exp_err, input logic [31:0] exp_rd);
        int gcyc;
        mem_word = mword;
        mem_lat  = 0;
        exp_if_q.push_back({exp_err, exp_rd});
        if_issue(name, addr, gcyc);
        @(negedge clk);
        total++;
        if (exp_err) begin
            if (mem_req_o !== 1'b0) begin bad++; $display("FAIL %s mem_req: got %b want 0", name, mem_req_o); end
        end else if ({mem_req_o, mem_addr_o, mem_we_o, mem_be_o} !== {1'b1, addr[31:2], 2'b00, 1'b0, 4'b1111}) begin
            bad++;
            $display("FAIL %s mem_ctl: got req=%b addr=%h we=%b be=%b want 1/%h/0/1111",
                     name, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, {addr[31:2], 2'b00});
        end
        wait_drain(name);
        total++;
        if ((last_rv_cyc - gcyc) != (exp_err ? 1 : 2)) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, last_rv_cyc - gcyc, exp_err ? 1 : 2);
        end
    endtask

    task automatic conflict(input string name);
        bit gi = 0;
        bit gl = 0;
        int ci = 0;
        int cl = 0;
        mem_lat  = 0;
        mem_word = 32'h1111_2222;
        exp_if_q.push_back({1'b0, 32'h1111_2222});
        exp_ls_q.push_back({1'b0, 32'h1111_2222});
        @(posedge clk);
        #1;
        if_req_i = 1'b1; if_addr_i = 32'h0;
        ls_req_i = 1'b1; ls_addr_i = 32'h1000; ls_read_i = MEM_READ_WORD; ls_write_i = MEM_WRITE_NONE;
        for (int i = 0; i < 30 && !(gi && gl); i++) begin
            @(negedge clk);
            if (if_gnt_o && !gi) begin gi = 1; ci = cyc; end
            if (ls_gnt_o && !gl) begin gl = 1; cl = cyc; end
            @(posedge clk);
            #1;
            if (gi) if_req_i = 1'b0;
            if (gl) begin ls_req_i = 1'b0; ls_read_i = MEM_READ_NONE; end
        end
        total++;
        if (!(gi && gl)) begin bad++; $display("FAIL %s both_granted: got if=%b ls=%b want 1/1", name, gi, gl); end
        total++;
        if ((ci - cl) != 3) begin bad++; $display("FAIL %s order: got if_gnt-ls_gnt=%0d want 3 (LS first)", name, ci - cl); end
        wait_drain(name);
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
             mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== 140'h0) begin
            bad++;
            $display("FAIL %s outputs: got gnt=%b%b rv=%b%b mem_req=%b addr=%h want all 0",
                     name, if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        if_req_i = 0; if_addr_i = 0; ls_req_i = 0; ls_addr_i = 0;
        ls_read_i = 0; ls_write_i = 0; ls_wdata_i = 0;
        #12;
        check_all_zero("reset_held");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");
    endtask

    task automatic test_arbitration;
        conflict("conflict1");
        conflict("conflict2");
    endtask

    task automatic test_fetch;
        if_txn("if_basic", 32'h0000_0010, 32'h0000_0013, 1'b0, 32'h0000_0013);
        if_txn("if_last_word", 32'h0000_2FFC, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001);
        if_txn("if_misaligned", 32'h0000_0002, 32'h1, 1'b1, BAD_VAL);
        if_txn("if_out_of_range", 32'h0000_3000, 32'h1, 1'b1, BAD_VAL);
    endtask

    task automatic test_loads;
        ls_txn("lb_1003", 32'h1003, MEM_READ_BYTE, MEM_WRITE_NONE, 0, 32'h80FF_0000, 1'b0, 32'hFFFF_FF80, 4'b1111, 0);
        ls_txn("lbu_1003", 32'h1003, MEM_READ_BYTE_U, MEM_WRITE_NONE, 0, 32'h80FF_0000, 1'b0, 32'h0000_0080, 4'b1111, 0);
        ls_txn("lb_1002", 32'h1002, MEM_READ_BYTE, MEM_WRITE_NONE, 0, 32'h80FF_0000, 1'b0, 32'hFFFF_FFFF, 4'b1111, 0);
        ls_txn("lh_1002", 32'h1002, MEM_READ_HALF, MEM_WRITE_NONE, 0, 32'h80FF_0000, 1'b0, 32'hFFFF_80FF, 4'b1111, 0);
        ls_txn("lhu_1002", 32'h1002, MEM_READ_HALF_U, MEM_WRITE_NONE, 0, 32'h80FF_0000, 1'b0, 32'h0000_80FF, 4'b1111, 0);
        ls_txn("lw_2ffc", 32'h2FFC, MEM_READ_WORD, MEM_WRITE_NONE, 0, 32'h1234_5678, 1'b0, 32'h1234_5678, 4'b1111, 0);
    endtask

    task automatic test_stores;
        ls_txn("sh_1002", 32'h1002, MEM_READ_NONE, MEM_WRITE_HALF, 32'h1234_ABCD, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'b1100, 32'hABCD_ABCD);
        ls_txn("sb_1001", 32'h1001, MEM_READ_NONE, MEM_WRITE_BYTE, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'b0010, 32'hA5A5_A5A5);
        ls_txn("sb_1000", 32'h1000, MEM_READ_NONE, MEM_WRITE_BYTE, 32'h0000_0077, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'b0001, 32'h7777_7777);
        ls_txn("sw_1008", 32'h1008, MEM_READ_NONE, MEM_WRITE_WORD, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'b1111, 32'hCAFE_F00D);
    endtask

    task automatic test_errors;
        ls_txn("lw_misaligned", 32'h1001, MEM_READ_WORD, MEM_WRITE_NONE, 0, 32'h1, 1'b1, BAD_VAL, 4'h0, 0);
        ls_txn("lh_misaligned", 32'h1001, MEM_READ_HALF, MEM_WRITE_NONE, 0, 32'h1, 1'b1, BAD_VAL, 4'h0, 0);
        ls_txn("sw_rom", 32'h0100, MEM_READ_NONE, MEM_WRITE_WORD, 32'h5, 32'h1, 1'b1, BAD_VAL, 4'h0, 0);
        ls_txn("sb_rom_top", 32'h0FFF, MEM_READ_NONE, MEM_WRITE_BYTE, 32'h5, 32'h1, 1'b1, BAD_VAL, 4'h0, 0);
        ls_txn("lw_3000", 32'h3000, MEM_READ_WORD, MEM_WRITE_NONE, 0, 32'h1, 1'b1, BAD_VAL, 4'h0, 0);
        ls_txn("type_none", 32'h1000, MEM_READ_NONE, MEM_WRITE_NONE, 0, 32'h1, 1'b1, BAD_VAL, 4'h0, 0);
        ls_txn("type_both", 32'h1000, MEM_READ_WORD, MEM_WRITE_WORD, 0, 32'h1, 1'b1, BAD_VAL, 4'h0, 0);
    endtask

    task automatic watchdog_case(input string name, input int lat, input logic exp_err);
        int gcyc;
        int n = 0;
        bit dropped = 0;
        mem_lat  = lat;
        mem_word = 32'h5555_AAAA;
        exp_ls_q.push_back({exp_err, exp_err ? BAD_VAL : 32'h5555_AAAA});
        ls_issue(name, 32'h1000, MEM_READ_WORD, MEM_WRITE_NONE, 0, gcyc);
        for (int i = 0; i < 40 && !dropped; i++) begin
            @(negedge clk);
            if (mem_req_o) n++;
            else dropped = 1;
        end
        total++;
        if (n != 16) begin bad++; $display("FAIL %s busy_cycles: got %0d want 16", name, n); end
        wait_drain(name);
        mem_lat = 0;
    endtask

    task automatic test_watchdog;
        watchdog_case("wd_expire", 1000, 1'b1);
        watchdog_case("wd_ready_last", 15, 1'b0);
    endtask

    task automatic test_reset_in_busy;
        int gcyc;
        int rv0;
        mem_lat = 1000;
        if_issue("rst_busy", 32'h20, gcyc);
        @(negedge clk);
        total++;
        if (mem_req_o !== 1'b1) begin bad++; $display("FAIL rst_busy mem_req: got %b want 1", mem_req_o); end
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst_busy_async");
        rv0 = rv_count;
        @(negedge clk);
        #2 rst_n = 1'b1;
        mem_lat = 0;
        repeat (6) @(negedge clk);
        total++;
        if (rv_count != rv0) begin bad++; $display("FAIL rst_busy no_rvalid: got %0d responses want 0", rv_count - rv0); end
        conflict("post_reset_conflict");
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_fetch();
        test_loads();
        test_stores();
        test_errors();
        test_watchdog();
        test_reset_in_busy();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
